// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] BOOT_PC = '0;
  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            except;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order ring pairing each reserved PC with its returning instruction.
// Three wrap-bit pointers: tail (reserve), fill (response), head (output).
module fetch_ring
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reserve,
  input  logic [XLEN-1:0]  reserve_pc,
  input  logic             fill_en,
  input  logic [ILEN-1:0]  fill_instr,
  input  logic             fill_except,
  input  logic             pop,
  input  logic             flush,
  output logic [PW-1:0]    used,
  output logic [PW-1:0]    pending,
  output logic             nonempty,
  output fetch_slot_t      head_slot
);

  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0]   tail, fill, head;
  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [ILEN-1:0] instr_mem  [DEPTH];
  logic            except_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
      fill <= '0;
      head <= '0;
    end else begin
      if (flush) begin
        head <= tail;
        fill <= tail;
      end else begin
        if (fill_en) fill <= fill + ONE;
        if (pop)     head <= head + ONE;
      end
      if (reserve) tail <= tail + ONE;
    end
  end

  // Slot payload is not reset; the output mux hides it while the ring is empty.
  always_ff @(posedge clk) begin
    if (reserve) pc_mem[tail[PW-2:0]] <= reserve_pc;
    if (fill_en) begin
      instr_mem[fill[PW-2:0]]  <= fill_instr;
      except_mem[fill[PW-2:0]] <= fill_except;
    end
  end

  assign used     = tail - head;
  assign pending  = tail - fill;
  assign nonempty = (fill != head);

  always_comb begin
    head_slot = '0;
    if (nonempty) begin
      head_slot.pc     = pc_mem[head[PW-2:0]];
      head_slot.instr  = instr_mem[head[PW-2:0]];
      head_slot.except = except_mem[head[PW-2:0]];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request per PC, buffers responses in
// order, presents them to decode and drops responses owed to a flushed stream.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [ILEN-1:0] mem_rsp_instr_i,
  input  logic            mem_rsp_except_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic            instr_except_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] used, pending, drop_cnt, drop_next;
  logic [PW:0]   occ;
  logic          nonempty, accept, fill_en, pop;
  fetch_slot_t   head_slot;

  // Stale responses still owed count against capacity like live slots.
  assign occ             = {1'b0, used} + {1'b0, drop_cnt};
  assign mem_req_valid_o = !flush_i && (occ < (PW+1)'(DEPTH));
  assign mem_req_addr_o  = pc_i;
  assign accept          = mem_req_valid_o && mem_req_ready_i;
  assign fetch_ready_o   = accept || flush_i;

  assign fill_en       = mem_rsp_valid_i && !flush_i && (drop_cnt == '0);
  assign instr_valid_o = nonempty && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i;

  assign instr_pc_o     = head_slot.pc;
  assign instr_o        = head_slot.instr;
  assign instr_except_o = head_slot.except;

  // A response seen during a flush settles one owed response, whether it was
  // already a drop credit or one of the slots being abandoned now.
  always_comb begin
    drop_next = drop_cnt;
    if (flush_i)
      drop_next = drop_cnt + pending - PW'(mem_rsp_valid_i);
    else if (mem_rsp_valid_i && (drop_cnt != '0))
      drop_next = drop_cnt - PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt <= '0;
    else       drop_cnt <= drop_next;
  end

  fetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk_i),
    .rst        (rst_i),
    .reserve    (accept),
    .reserve_pc (pc_i),
    .fill_en    (fill_en),
    .fill_instr (mem_rsp_instr_i),
    .fill_except(mem_rsp_except_i),
    .pop        (pop),
    .flush      (flush_i),
    .used       (used),
    .pending    (pending),
    .nonempty   (nonempty),
    .head_slot  (head_slot)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC generator, in-order memory and decode models drive
// the DUT; an epoch-tagged queue model predicts every output each cycle.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = FETCH_DEPTH;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [XLEN-1:0] pc_i;
  logic            fetch_ready_o;
  logic            flush_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_rsp_valid_i;
  logic [ILEN-1:0] mem_rsp_instr_i;
  logic            mem_rsp_except_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_pc_o;
  logic [ILEN-1:0] instr_o;
  logic            instr_except_o;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .pc_i            (pc_i),
    .fetch_ready_o   (fetch_ready_o),
    .flush_i         (flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_instr_i (mem_rsp_instr_i),
    .mem_rsp_except_i(mem_rsp_except_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_pc_o      (instr_pc_o),
    .instr_o         (instr_o),
    .instr_except_o  (instr_except_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            exc;
    int              rdy;
    int              epoch;
  } mreq_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            exc;
  } ent_t;

  mreq_t           mq[$];   // requests accepted by memory, not yet answered
  ent_t            bq[$];   // live instructions received, not yet consumed
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              epoch = 0;
  logic [XLEN-1:0] pcg;
  int              p_ready, p_rsp, p_dready, p_flush, max_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic force_flush, input logic [XLEN-1:0] tgt);
    logic rsp_v, ev, efr, eiv, fl;
    logic [XLEN-1:0] target;
    mreq_t r;
    fl = force_flush || (int'($urandom_range(99)) < p_flush);
    target = force_flush ? tgt : (XLEN'($urandom_range(1023)) << 2);
    pc_i = pcg;
    flush_i = fl;
    mem_req_ready_i = int'($urandom_range(99)) < p_ready;
    instr_ready_i = int'($urandom_range(99)) < p_dready;
    rsp_v = (mq.size() > 0) && (mq[0].rdy <= cyc) && (int'($urandom_range(99)) < p_rsp);
    mem_rsp_valid_i = rsp_v;
    mem_rsp_instr_i = rsp_v ? mq[0].instr : $urandom;
    mem_rsp_except_i = rsp_v ? mq[0].exc : 1'($urandom_range(1));
    #1;
    ev  = !fl && ((mq.size() + bq.size()) < DEPTH);
    efr = (ev && mem_req_ready_i) || fl;
    eiv = (bq.size() != 0) && !fl;
    check("req_valid", 64'(mem_req_valid_o), 64'(ev));
    check("fetch_ready", 64'(fetch_ready_o), 64'(efr));
    check("req_addr", 64'(mem_req_addr_o), 64'(pcg));
    check("instr_valid", 64'(instr_valid_o), 64'(eiv));
    if (eiv) begin
      check("instr_pc", 64'(instr_pc_o), 64'(bq[0].pc));
      check("instr", 64'(instr_o), 64'(bq[0].instr));
      check("instr_except", 64'(instr_except_o), 64'(bq[0].exc));
    end
    if (eiv && instr_ready_i) void'(bq.pop_front());
    if (rsp_v) begin
      r = mq.pop_front();
      if (!fl && r.epoch == epoch) bq.push_back('{pc: r.pc, instr: r.instr, exc: r.exc});
    end
    if (fl) begin
      bq.delete();
      epoch++;
    end
    if (ev && mem_req_ready_i)
      mq.push_back('{pc: pcg, instr: $urandom,
                     exc: (pcg == 32'h100) || ($urandom_range(15) == 0),
                     rdy: cyc + int'($urandom_range(max_lat, 1)), epoch: epoch});
    if (efr) pcg = fl ? target : pcg + 32'd4;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic knobs(input int rdy, input int rsp, input int drdy, input int fl, input int lat);
    p_ready = rdy; p_rsp = rsp; p_dready = drdy; p_flush = fl; max_lat = lat;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0;
    mem_rsp_instr_i = '0; mem_rsp_except_i = 1'b0; instr_ready_i = 1'b0;
    pcg = BOOT_PC; pc_i = BOOT_PC;
    #1;
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd1);
    check("rst_fetch_ready", 64'(fetch_ready_o), 64'd1);
    check("rst_instr_valid", 64'(instr_valid_o), 64'd0);
    check("rst_instr_pc", 64'(instr_pc_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_except", 64'(instr_except_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // back-to-back, 1-cycle memory
    knobs(100, 100, 100, 0, 1);
    repeat (12) step(1'b0, '0);
    // decode stalled until the ring fills, then drains
    knobs(100, 100, 0, 0, 1);
    repeat (8) step(1'b0, '0);
    knobs(100, 100, 100, 0, 1);
    repeat (8) step(1'b0, '0);
    // flush with responses held back, redirect near the faulting PC 0x100
    knobs(100, 0, 100, 0, 1);
    repeat (3) step(1'b0, '0);
    step(1'b1, 32'h0F8);
    knobs(100, 100, 100, 0, 1);
    repeat (14) step(1'b0, '0);
    // flush while a response arrives in the same cycle
    knobs(100, 0, 100, 0, 1);
    repeat (2) step(1'b0, '0);
    knobs(100, 100, 100, 0, 1);
    step(1'b1, 32'h200);
    repeat (10) step(1'b0, '0);
    // random traffic with variable latency and occasional flushes
    knobs(70, 60, 70, 8, 4);
    repeat (400) step(1'b0, '0);

    // reset mid-stream with requests in flight and instructions buffered
    knobs(100, 50, 0, 0, 3);
    repeat (4) step(1'b0, '0);
    flush_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0; instr_ready_i = 1'b1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_instr_valid", 64'(instr_valid_o), 64'd0);
    check("mid_rst_req_valid", 64'(mem_req_valid_o), 64'd1);
    check("mid_rst_fetch_ready", 64'(fetch_ready_o), 64'(mem_req_ready_i));
    check("mid_rst_instr_pc", 64'(instr_pc_o), 64'd0);
    mq.delete();
    bq.delete();
    pcg = BOOT_PC;
    @(posedge clk);
    #1 rst_i = 1'b0;
    knobs(100, 100, 100, 0, 1);
    repeat (12) step(1'b0, '0);
    knobs(80, 70, 80, 5, 3);
    repeat (100) step(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
